// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported fixed-latency memory between the IF and data ports.
// Optional MEM_ARB_RR_EN: round-robin between ports instead of fixed data-over-IF priority.
module mem_arbiter #(
  parameter int AW  = 10,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  output logic          stall
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [2:0] CNT_RD = 3'(LAT - 1);

  state_t     state, state_next;
  logic [2:0] cnt;
  logic       op_we;
  logic       elig_i, elig_d;
  logic       grant_i, grant_d;
  logic       done;

  // A port whose ready is pulsing this cycle must not be granted again off the same held request.
  assign elig_i = if_req & ~if_ready;
  assign elig_d = d_req & ~d_ready;
  assign stall  = elig_i | elig_d;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (elig_i && elig_d) begin
        grant_d = ~last_d;
        grant_i = last_d;
      end else begin
        grant_d = elig_d;
        grant_i = elig_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (grant_d) begin
      last_d <= 1'b1;
    end else if (grant_i) begin
      last_d <= 1'b0;
    end
  end
`else
  always_comb begin
    grant_d = (state == IDLE) & elig_d;
    grant_i = (state == IDLE) & elig_i & ~elig_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_i) begin
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt == 3'd0) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // op_we remembers a store after m_we drops, so completion leaves d_rdata alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 3'd0;
      op_we    <= 1'b0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
    end else begin
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (grant_d) begin
        m_en    <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        op_we   <= d_we;
        cnt     <= d_we ? 3'd0 : CNT_RD;
      end else if (grant_i) begin
        m_en   <= 1'b1;
        m_addr <= if_addr;
        op_we  <= 1'b0;
        cnt    <= CNT_RD;
      end else if (done) begin
        if (state == BUSY_I) begin
          if_rdata <= m_rdata;
          if_ready <= 1'b1;
        end else begin
          if (!op_we) begin
            d_rdata <= m_rdata;
          end
          d_ready <= 1'b1;
        end
      end else if (state != IDLE) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural fixed-latency memory.
// Honours MEM_ARB_RR_EN for arbitration-order expectations; LAT may be overridden.
module tb_mem_arbiter #(
  parameter int LAT = 2
);

  localparam int AW = 10;
  localparam logic [31:0] POISON = 32'hBAD0_BAD0;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ready;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          stall;

  mem_arbiter #(.AW(AW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];

  int checks = 0;
  int fails  = 0;
  bit last_d_model = 1'b0;
  logic [31:0] d_rdata_model = 32'h0;

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Memory model: data is visible only in the LAT-th cycle after m_en, poison otherwise.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] pend_addr;
  int            pend_age;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(AW'(i));
    mem[1]    <= 32'h2008_0005;
    pend_addr <= '0;
    pend_age  <= 100;
  end

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    if (m_en && !m_we) begin
      pend_addr <= m_addr;
      pend_age  <= 1;
    end else if (pend_age < 100) begin
      pend_age <= pend_age + 1;
    end
  end

  always_comb begin
    m_rdata = POISON;
    if (LAT == 1) begin
      if (m_en && !m_we) m_rdata = mem[m_addr];
    end else if (pend_age == LAT - 1) begin
      m_rdata = mem[pend_addr];
    end
  end

  // Cycle counter and bus monitor.
  int            cyc = 0;
  int            men_count = 0;
  int            stall_cnt = 0;
  int            last_men_cyc = -1;
  logic          last_men_we = 1'b0;
  logic [AW-1:0] last_men_addr = '0;
  logic [31:0]   last_men_wdata = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stall === 1'b1) stall_cnt <= stall_cnt + 1;
    if (m_en === 1'b1) begin
      men_count      <= men_count + 1;
      last_men_cyc   <= cyc;
      last_men_we    <= m_we;
      last_men_addr  <= m_addr;
      last_men_wdata <= m_wdata;
    end
  end

  task automatic wait_ready(input bit is_d, input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if ((is_d ? d_ready : if_ready) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int c0, pulses;
    bit seen;
    exp_t e;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({m_en, m_we, if_ready, d_ready, m_addr, m_wdata, if_rdata, d_rdata, stall} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %h required 0",
               {m_en, m_we, if_ready, d_ready, m_addr, m_wdata, if_rdata, d_rdata, stall});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 'h005;
    @(negedge clk);
    #1;
    checks++;
    if (m_en !== 1'b1) begin
      fails++;
      $display("[TB] FAIL busy_before_reset m_en: got %b required 1", m_en);
    end
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({m_en, m_we, if_ready, d_ready, m_addr, m_wdata, if_rdata, d_rdata} !== '0) begin
      fails++;
      $display("[TB] FAIL midbusy_reset_outputs: got %h required 0",
               {m_en, m_we, if_ready, d_ready, m_addr, m_wdata, if_rdata, d_rdata});
    end
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (if_ready === 1'b1 || d_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      fails++;
      $display("[TB] FAIL stale_ready_after_reset: got %0d pulses required 0", pulses);
    end
    last_d_model  = 1'b0;
    d_rdata_model = 32'h0;
    @(negedge clk);
    c0 = cyc;
    if_req = 1'b1; if_addr = 'h001;
    if_q.push_back('{32'h2008_0005, c0 + LAT + 1});
    wait_ready(1'b0, 20, seen);
    if_req = 1'b0;
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL post_reset_if_timeout: got no if_ready required one");
    end else begin
      e = if_q.pop_front();
      checks++;
      if (if_rdata !== e.data || cyc != e.cyc) begin
        fails++;
        $display("[TB] FAIL post_reset_if_read: got %h @%0d required %h @%0d",
                 if_rdata, cyc, e.data, e.cyc);
      end
    end
    if_q.delete();
  endtask

  task automatic test_if_read();
    int c0, men0, st0;
    bit seen;
    exp_t e;
    @(negedge clk);
    c0 = cyc; men0 = men_count; st0 = stall_cnt;
    if_req = 1'b1; if_addr = 'h001;
    if_q.push_back('{32'h2008_0005, c0 + LAT + 1});
    #1;
    checks++;
    if (stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL if_stall_cycle0: got %b required 1", stall);
    end
    wait_ready(1'b0, 20, seen);
    if_req = 1'b0;
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL if_read_timeout: got no if_ready required one");
    end else begin
      e = if_q.pop_front();
      checks++;
      if (if_rdata !== e.data || cyc != e.cyc) begin
        fails++;
        $display("[TB] FAIL if_read_data: got %h @%0d required %h @%0d", if_rdata, cyc, e.data, e.cyc);
      end
      checks++;
      if (men_count - men0 != 1 || last_men_cyc != c0 + 1 || last_men_we !== 1'b0 ||
          last_men_addr !== AW'(1)) begin
        fails++;
        $display("[TB] FAIL if_men: got n=%0d @%0d we=%b a=%h required n=1 @%0d we=0 a=001",
                 men_count - men0, last_men_cyc, last_men_we, last_men_addr, c0 + 1);
      end
      checks++;
      if (stall_cnt - st0 != LAT + 1 || stall !== 1'b0) begin
        fails++;
        $display("[TB] FAIL if_stall_span: got %0d cycles (now %b) required %0d (now 0)",
                 stall_cnt - st0, stall, LAT + 1);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (if_ready !== 1'b0 || men_count - men0 != 1) begin
      fails++;
      $display("[TB] FAIL if_ready_width: got ready=%b men=%0d required ready=0 men=1",
               if_ready, men_count - men0);
    end
    last_d_model = 1'b0;
    if_q.delete();
  endtask

  task automatic test_store_load();
    int c0;
    bit seen;
    exp_t e;
    @(negedge clk);
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 'h010; d_wdata = 32'hDEAD_BEEF;
    d_q.push_back('{d_rdata_model, c0 + 2});
    wait_ready(1'b1, 20, seen);
    d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h1234_5678;
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL store_timeout: got no d_ready required one");
    end else begin
      e = d_q.pop_front();
      checks++;
      if (d_rdata !== e.data || cyc != e.cyc) begin
        fails++;
        $display("[TB] FAIL store_ready: got %h @%0d required %h @%0d", d_rdata, cyc, e.data, e.cyc);
      end
      checks++;
      if (last_men_cyc != c0 + 1 || last_men_we !== 1'b1 || last_men_addr !== AW'('h010) ||
          last_men_wdata !== 32'hDEAD_BEEF) begin
        fails++;
        $display("[TB] FAIL store_bus: got @%0d we=%b a=%h d=%h required @%0d we=1 a=010 d=deadbeef",
                 last_men_cyc, last_men_we, last_men_addr, last_men_wdata, c0 + 1);
      end
    end
    @(negedge clk);
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 'h010;
    d_q.push_back('{32'hDEAD_BEEF, c0 + LAT + 1});
    wait_ready(1'b1, 20, seen);
    d_req = 1'b0;
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL load_timeout: got no d_ready required one");
    end else begin
      e = d_q.pop_front();
      checks++;
      if (d_rdata !== e.data || cyc != e.cyc) begin
        fails++;
        $display("[TB] FAIL load_after_store: got %h @%0d required %h @%0d", d_rdata, cyc, e.data, e.cyc);
      end
      checks++;
      if (last_men_we !== 1'b0 || m_we !== 1'b0) begin
        fails++;
        $display("[TB] FAIL load_we: got %b/%b required 0/0", last_men_we, m_we);
      end
    end
    d_rdata_model = 32'hDEAD_BEEF;
    last_d_model  = 1'b1;
    d_q.delete();
  endtask

  // Both ports request together; addresses change after the first grant, so the
  // second port must use its updated address and the first its original one.
  task automatic test_simultaneous();
    int c0, men0;
    bit first_d, got_i, got_d;
    exp_t e;
    first_d = 1'b1;
`ifdef MEM_ARB_RR_EN
    first_d = ~last_d_model;
`endif
    @(negedge clk);
    c0 = cyc; men0 = men_count;
    d_req = 1'b1; d_we = 1'b0; d_addr = 'h020;
    if_req = 1'b1; if_addr = 'h030;
    if (first_d) begin
      d_q.push_back('{init_word('h020), c0 + LAT + 1});
      if_q.push_back('{init_word('h031), c0 + 2 * (LAT + 1)});
    end else begin
      if_q.push_back('{init_word('h030), c0 + LAT + 1});
      d_q.push_back('{init_word('h021), c0 + 2 * (LAT + 1)});
    end
    @(negedge clk);
    d_addr = 'h021; if_addr = 'h031;
    got_i = 1'b0; got_d = 1'b0;
    for (int k = 0; k < 40 && !(got_i && got_d); k++) begin
      @(negedge clk);
      #1;
      if (if_ready === 1'b1) begin
        checks++;
        if (if_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL sim_if_extra: got if_ready @%0d required none", cyc);
        end else begin
          e = if_q.pop_front();
          if (if_rdata !== e.data || cyc != e.cyc) begin
            fails++;
            $display("[TB] FAIL sim_if_read: got %h @%0d required %h @%0d", if_rdata, cyc, e.data, e.cyc);
          end
        end
        got_i = 1'b1; if_req = 1'b0;
      end
      if (d_ready === 1'b1) begin
        checks++;
        if (d_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL sim_d_extra: got d_ready @%0d required none", cyc);
        end else begin
          e = d_q.pop_front();
          if (d_rdata !== e.data || cyc != e.cyc) begin
            fails++;
            $display("[TB] FAIL sim_d_read: got %h @%0d required %h @%0d", d_rdata, cyc, e.data, e.cyc);
          end
        end
        got_d = 1'b1; d_req = 1'b0;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    checks++;
    if (!(got_i && got_d)) begin
      fails++;
      $display("[TB] FAIL sim_timeout: got if=%b d=%b required both", got_i, got_d);
    end
    @(negedge clk);
    #1;
    checks++;
    if (men_count - men0 != 2) begin
      fails++;
      $display("[TB] FAIL sim_men_pulses: got %0d required 2", men_count - men0);
    end
    last_d_model  = ~first_d;
    d_rdata_model = first_d ? init_word('h020) : init_word('h021);
    if_q.delete(); d_q.delete();
  endtask

  // Both requests held throughout: the granted port's own ready pulse blocks it
  // for one cycle, so the other port is always granted next and grants alternate.
  task automatic test_back_to_back();
    int c0, men0, got, d_idx;
    bit first_d, port, exp_port;
    bit order_q[$];
    exp_t e;
    first_d = 1'b1;
`ifdef MEM_ARB_RR_EN
    first_d = ~last_d_model;
`endif
    @(negedge clk);
    c0 = cyc; men0 = men_count;
    if_req = 1'b1; if_addr = 'h050;
    d_req = 1'b1; d_we = 1'b0; d_addr = 'h040;
    d_idx = 0;
    for (int k = 0; k < 4; k++) begin
      port = first_d ^ k[0];
      order_q.push_back(port);
      if (port) begin
        d_q.push_back('{init_word(AW'('h040 + d_idx)), c0 + (k + 1) * (LAT + 1)});
        d_idx++;
      end else begin
        if_q.push_back('{init_word('h050), c0 + (k + 1) * (LAT + 1)});
      end
    end
    d_idx = 0;
    got = 0;
    for (int k = 0; k < 80 && got < 4; k++) begin
      @(negedge clk);
      #1;
      if (if_ready === 1'b1 || d_ready === 1'b1) begin
        port = (d_ready === 1'b1);
        exp_port = order_q.pop_front();
        checks++;
        if ((if_ready === 1'b1 && d_ready === 1'b1) || port != exp_port) begin
          fails++;
          $display("[TB] FAIL b2b_order[%0d]: got if=%b d=%b required port %s",
                   got, if_ready, d_ready, exp_port ? "data" : "if");
        end
        if (port) begin
          e = d_q.pop_front();
          checks++;
          if (d_rdata !== e.data || cyc != e.cyc) begin
            fails++;
            $display("[TB] FAIL b2b_d_read[%0d]: got %h @%0d required %h @%0d",
                     got, d_rdata, cyc, e.data, e.cyc);
          end
          d_rdata_model = e.data;
          d_idx++;
          d_addr = AW'('h040 + d_idx);
        end else begin
          e = if_q.pop_front();
          checks++;
          if (if_rdata !== e.data || cyc != e.cyc) begin
            fails++;
            $display("[TB] FAIL b2b_if_read[%0d]: got %h @%0d required %h @%0d",
                     got, if_rdata, cyc, e.data, e.cyc);
          end
        end
        last_d_model = port;
        got++;
        if (got == 4) begin
          if_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    checks++;
    if (got != 4) begin
      fails++;
      $display("[TB] FAIL b2b_timeout: got %0d grants required 4", got);
    end
    @(negedge clk);
    #1;
    checks++;
    if (men_count - men0 != 4) begin
      fails++;
      $display("[TB] FAIL b2b_men_pulses: got %0d required 4", men_count - men0);
    end
    if_q.delete(); d_q.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] mem_arbiter bench, LAT=%0d", LAT);
    test_reset();
    test_if_read();
    test_store_load();
    test_simultaneous();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
